// File: rtl/vehicle_sensor_conditioner.sv
// vehicle_sensor_conditioner
//   Conditions the raw inductive-loop detector signal for the traffic light
//   controller. It synchronizes and debounces the loop input, stretches demand
//   across short gaps between vehicles, counts arrivals (saturating) and flags
//   a loop that stays occupied too long.
//
// Ports
//   clk           : sole clock, rising edge
//   reset         : synchronous, active-high reset
//   raw_loop      : asynchronous loop detector output (1 = vehicle present)
//   count_clr     : synchronous clear of vehicle_count
//   sensor        : registered demand to the light controller
//   arrival_pulse : one-cycle strobe per accepted arrival
//   vehicle_count : saturating arrival count
//   stuck_fault   : loop occupied for longer than STUCK_CYCLES
module vehicle_sensor_conditioner #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int HOLD_CYCLES     = 20,
   parameter int STUCK_CYCLES    = 200,
   parameter int COUNT_WIDTH     = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   raw_loop,
   input  logic                   count_clr,
   output logic                   sensor,
   output logic                   arrival_pulse,
   output logic [COUNT_WIDTH-1:0] vehicle_count,
   output logic                   stuck_fault
);

   // Each timer is wide enough to hold its full parameter value.
   localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
   localparam int OCC_W  = $clog2(STUCK_CYCLES + 1);

   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [OCC_W-1:0]  OCC_LAST  = OCC_W'(STUCK_CYCLES - 1);
   localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      OCCUPIED = 2'd1,
      HOLD     = 2'd2,
      FAULT    = 2'd3
   } state_t;

   state_t state, next_state;

   logic              s1, s2, filt;
   logic [DB_W-1:0]   db_cnt;
   logic [HOLD_W-1:0] hold_cnt;
   logic [OCC_W-1:0]  occ_cnt;
   logic              arrival;

   // Synchronizer and debounce. filt only follows s2 after DEBOUNCE_CYCLES
   // consecutive disagreeing samples; any agreeing sample restarts the count.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1     <= 1'b0;
         s2     <= 1'b0;
         filt   <= 1'b0;
         db_cnt <= '0;
      end else begin
         s1 <= raw_loop;
         s2 <= s1;
         if (s2 == filt) begin
            db_cnt <= '0;
         end else if (db_cnt == DB_LAST) begin
            filt   <= s2;
            db_cnt <= '0;
         end else begin
            db_cnt <= db_cnt + 1'b1;
         end
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   // Next-state logic; arrival marks every transition into OCCUPIED from a
   // non-fault state.
   always_comb begin
      next_state = state;
      arrival    = 1'b0;
      case (state)
         IDLE: begin
            if (filt) begin
               next_state = OCCUPIED;
               arrival    = 1'b1;
            end
         end
         OCCUPIED: begin
            if (!filt)                   next_state = HOLD;
            else if (occ_cnt == OCC_LAST) next_state = FAULT;
         end
         HOLD: begin
            // A re-arrival wins over the hold timeout.
            if (filt) begin
               next_state = OCCUPIED;
               arrival    = 1'b1;
            end else if (hold_cnt == HOLD_LAST) begin
               next_state = IDLE;
            end
         end
         FAULT: begin
            if (!filt) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Timers, counter and outputs. Outputs are registered from next_state so
   // they change on the same edge as the state and never glitch.
   always_ff @(posedge clk) begin
      if (reset) begin
         occ_cnt       <= '0;
         hold_cnt      <= '0;
         vehicle_count <= '0;
         sensor        <= 1'b0;
         stuck_fault   <= 1'b0;
         arrival_pulse <= 1'b0;
      end else begin
         // Both timers restart on entry and count the cycles spent in state.
         if (next_state == OCCUPIED && state != OCCUPIED) occ_cnt <= '0;
         else if (state == OCCUPIED)                      occ_cnt <= occ_cnt + 1'b1;

         if (next_state == HOLD && state != HOLD) hold_cnt <= '0;
         else if (state == HOLD)                  hold_cnt <= hold_cnt + 1'b1;

         // A clear coincident with an arrival leaves that arrival counted.
         if (arrival) begin
            if (count_clr)                       vehicle_count <= COUNT_WIDTH'(1);
            else if (vehicle_count != COUNT_MAX) vehicle_count <= vehicle_count + 1'b1;
         end else if (count_clr) begin
            vehicle_count <= '0;
         end

         sensor        <= (next_state != IDLE);
         stuck_fault   <= (next_state == FAULT);
         arrival_pulse <= arrival;
      end
   end

endmodule

// File: tb/tb_vehicle_sensor_conditioner.sv
// Scoreboard bench for vehicle_sensor_conditioner (defaults, COUNT_WIDTH=2).
// Stimulus pushes each expected output change {cycle, outputs} into a queue;
// the monitor pops one entry whenever the DUT output tuple changes and
// compares both the values and the cycle at which the change appeared.
module tb_vehicle_sensor_conditioner;
   localparam int CW = 2;
   localparam int VW = CW + 3;

   logic          clk = 1'b0;
   logic          reset, raw_loop, count_clr;
   logic          sensor, arrival_pulse, stuck_fault;
   logic [CW-1:0] vehicle_count;

   typedef struct {
      int            cyc;
      logic [VW-1:0] v;
   } exp_t;

   exp_t          q[$];
   exp_t          e;
   int            cyc = 0;
   int            checks = 0;
   int            failures = 0;
   int            t;
   logic [VW-1:0] prev, cur;
   bit            mon_en = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   vehicle_sensor_conditioner #(
      .DEBOUNCE_CYCLES(4),
      .HOLD_CYCLES(20),
      .STUCK_CYCLES(200),
      .COUNT_WIDTH(CW)
   ) dut (
      .clk(clk),
      .reset(reset),
      .raw_loop(raw_loop),
      .count_clr(count_clr),
      .sensor(sensor),
      .arrival_pulse(arrival_pulse),
      .vehicle_count(vehicle_count),
      .stuck_fault(stuck_fault)
   );

   function automatic logic [VW-1:0] pk(logic s, logic a, logic f, logic [CW-1:0] n);
      return {s, a, f, n};
   endfunction

   task automatic expect_at(input int c, input logic [VW-1:0] v);
      exp_t x;
      x.cyc = c;
      x.v   = v;
      q.push_back(x);
   endtask

   task automatic go(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [VW-1:0] want);
      logic [VW-1:0] got;
      got = {sensor, arrival_pulse, stuck_fault, vehicle_count};
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%b want=%b (sensor,arrival,stuck,count)", name, cyc, got, want);
      end
   endtask

   // Monitor: any change of the output tuple must match the next scoreboard entry.
   always @(negedge clk) begin
      if (mon_en) begin
         cur = {sensor, arrival_pulse, stuck_fault, vehicle_count};
         if (cur !== prev) begin
            checks++;
            if (q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_change cyc=%0d got=%b", cyc, cur);
            end else begin
               e = q.pop_front();
               if (e.cyc != cyc || e.v !== cur) begin
                  failures++;
                  $display("FAIL output_event got cyc=%0d val=%b want cyc=%0d val=%b", cyc, cur, e.cyc, e.v);
               end
            end
            prev = cur;
         end
      end
   end

   initial begin
      #100000;
      failures++;
      $display("FAIL watchdog cyc=%0d pending=%0d", cyc, q.size());
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1; raw_loop = 1'b0; count_clr = 1'b0;
      go(3);
      chk("reset_state", pk(0, 0, 0, 0));
      reset = 1'b0;
      prev = pk(0, 0, 0, 0);
      mon_en = 1'b1;
      go(2);

      // Clean arrival: pulse/sensor at edge 7, sensor falls 20 after HOLD entry.
      t = cyc; raw_loop = 1'b1;
      expect_at(t + 7, pk(1, 1, 0, 1));
      expect_at(t + 8, pk(1, 0, 0, 1));
      go(30); raw_loop = 1'b0;
      expect_at(t + 57, pk(0, 0, 0, 1));
      go(40);
      chk("after_clean", pk(0, 0, 0, 1));

      // 3-cycle glitch is rejected.
      raw_loop = 1'b1; go(3); raw_loop = 1'b0; go(20);
      chk("glitch3_rejected", pk(0, 0, 0, 1));

      // 4-cycle pulse is accepted.
      t = cyc; raw_loop = 1'b1;
      expect_at(t + 7, pk(1, 1, 0, 2));
      expect_at(t + 8, pk(1, 0, 0, 2));
      expect_at(t + 31, pk(0, 0, 0, 2));
      go(4); raw_loop = 1'b0; go(45);

      // Clear with no arrival.
      t = cyc; count_clr = 1'b1;
      expect_at(t + 1, pk(0, 0, 0, 0));
      go(1); count_clr = 1'b0; go(2);

      // Gap extension: re-arrival 10 cycles into HOLD keeps sensor high.
      t = cyc; raw_loop = 1'b1;
      expect_at(t + 7, pk(1, 1, 0, 1));
      expect_at(t + 8, pk(1, 0, 0, 1));
      go(15); raw_loop = 1'b0;          // HOLD entered at t+22
      go(10); raw_loop = 1'b1;          // back to OCCUPIED at t+32
      expect_at(t + 32, pk(1, 1, 0, 2));
      expect_at(t + 33, pk(1, 0, 0, 2));
      go(15); raw_loop = 1'b0;          // HOLD at t+47
      expect_at(t + 67, pk(0, 0, 0, 2));
      go(40);

      // Stuck loop: fault 200 cycles after OCCUPIED entry, no hold on release.
      t = cyc; raw_loop = 1'b1;
      expect_at(t + 7, pk(1, 1, 0, 3));
      expect_at(t + 8, pk(1, 0, 0, 3));
      expect_at(t + 207, pk(1, 0, 1, 3));
      go(300); raw_loop = 1'b0;
      expect_at(t + 307, pk(0, 0, 0, 3));
      go(15);
      chk("after_fault", pk(0, 0, 0, 3));

      // Saturation: four arrivals from zero give 1,2,3,3.
      t = cyc; count_clr = 1'b1;
      expect_at(t + 1, pk(0, 0, 0, 0));
      go(1); count_clr = 1'b0; go(2);
      for (int k = 1; k <= 4; k++) begin
         logic [CW-1:0] n;
         n = (k > 3) ? CW'(3) : CW'(k);
         t = cyc; raw_loop = 1'b1;
         expect_at(t + 7, pk(1, 1, 0, n));
         expect_at(t + 8, pk(1, 0, 0, n));
         expect_at(t + 35, pk(0, 0, 0, n));
         go(8); raw_loop = 1'b0; go(37);
      end

      // Clear coincident with an arrival gives 1; then reset mid-HOLD.
      t = cyc; raw_loop = 1'b1;
      expect_at(t + 7, pk(1, 1, 0, 1));
      expect_at(t + 8, pk(1, 0, 0, 1));
      go(6); count_clr = 1'b1; go(1); count_clr = 1'b0;
      go(1); raw_loop = 1'b0;           // HOLD at t+15
      go(12);
      expect_at(t + 21, pk(0, 0, 0, 0));
      reset = 1'b1; go(1); reset = 1'b0;
      chk("reset_mid_hold", pk(0, 0, 0, 0));

      // Loop held high across reset: re-accepted 7 edges after deassertion.
      go(5);
      t = cyc; raw_loop = 1'b1;
      expect_at(t + 7, pk(1, 1, 0, 1));
      expect_at(t + 8, pk(1, 0, 0, 1));
      go(12);
      expect_at(t + 13, pk(0, 0, 0, 0));
      reset = 1'b1; go(1); reset = 1'b0;
      expect_at(t + 20, pk(1, 1, 0, 1));
      expect_at(t + 21, pk(1, 0, 0, 1));
      go(12); raw_loop = 1'b0;
      expect_at(t + 52, pk(0, 0, 0, 1));
      go(35);

      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL missing_events pending=%0d next_cyc=%0d", q.size(), q[0].cyc);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
